// File: rtl/pixel_sensor_controller_pkg.sv
// Shared configuration for the pixel sensor controller: default sizes, FSM state type
// and a helper for index widths that must stay at least one bit wide.
package pixel_sensor_controller_pkg;

    localparam int DEFAULT_PIXEL_BITS    = 8;
    localparam int DEFAULT_NUM_PIXELS    = 4;
    localparam int DEFAULT_ERASE_CYCLES  = 4;
    localparam int DEFAULT_EXPOSE_CYCLES = 255;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READOUT
    } ctrl_state_t;

    function automatic int index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/pixel_sensor_controller_latch.sv
// Per-pixel code capture: the first qualifying comparator trip stores the current ramp slot,
// and a pixel that never trips is forced to full scale when conversion ends.
module pixel_code_latch
    import pixel_sensor_controller_pkg::*;
#(
    parameter int PIXEL_BITS = DEFAULT_PIXEL_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  sample,
    input  logic                  saturate,
    input  logic                  cmp,
    input  logic [PIXEL_BITS-1:0] slot,
    output logic [PIXEL_BITS-1:0] code,
    output logic                  latched
);

    // A trip in the final sample wins over saturation, which only fills pixels still unlatched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code    <= '0;
            latched <= 1'b0;
        end else if (clear) begin
            code    <= '0;
            latched <= 1'b0;
        end else if (sample && cmp && !latched) begin
            code    <= slot;
            latched <= 1'b1;
        end else if (saturate && !latched) begin
            code    <= '1;
            latched <= 1'b1;
        end
    end

endmodule

// File: rtl/pixel_sensor_controller.sv
// Sequences erase, expose and single-slope conversion for a bank of pixels, then streams
// the captured codes out one pixel per valid/ready transfer.
module pixel_sensor_controller
    import pixel_sensor_controller_pkg::*;
#(
    parameter  int PIXEL_BITS    = DEFAULT_PIXEL_BITS,
    parameter  int NUM_PIXELS    = DEFAULT_NUM_PIXELS,
    parameter  int ERASE_CYCLES  = DEFAULT_ERASE_CYCLES,
    parameter  int EXPOSE_CYCLES = DEFAULT_EXPOSE_CYCLES,
    localparam int IDX_W         = index_width(NUM_PIXELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_PIXELS-1:0] cmp,
    output logic                  erase,
    output logic                  expose,
    output logic                  ramp,
    output logic                  busy,
    output logic [PIXEL_BITS-1:0] data,
    output logic [IDX_W-1:0]      pix_index,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  frame_done
);

    localparam int PHASE_MAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam logic [PIXEL_BITS-1:0] LAST_SLOT = '1;

    ctrl_state_t           state;
    logic [PHASE_W-1:0]    phase_cnt;
    logic [PIXEL_BITS-1:0] slot;
    logic [PIXEL_BITS-1:0] codes [NUM_PIXELS];
    logic [NUM_PIXELS-1:0] latched;

    logic start_frame;
    logic sample;
    logic saturate;
    logic all_tripped;
    logic transfer;
    logic last_pixel;

    // The frame_done cycle is already IDLE, so start is masked there to avoid an instant restart.
    assign start_frame = (state == IDLE) && start && !frame_done;
    assign sample      = (state == CONVERT) && !ramp;
    assign saturate    = sample && (slot == LAST_SLOT);
    assign all_tripped = &(latched | cmp);
    assign transfer    = data_valid && data_ready;
    assign last_pixel  = (pix_index == IDX_W'(NUM_PIXELS - 1));
    assign data        = data_valid ? codes[pix_index] : '0;

    for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_pixel
        pixel_code_latch #(
            .PIXEL_BITS (PIXEL_BITS)
        ) u_latch (
            .clk      (clk),
            .reset    (reset),
            .clear    (start_frame),
            .sample   (sample),
            .saturate (saturate),
            .cmp      (cmp[i]),
            .slot     (slot),
            .code     (codes[i]),
            .latched  (latched[i])
        );
    end

    // Outputs are registered alongside the state so they change exactly on state boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            slot       <= '0;
            pix_index  <= '0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            ramp       <= 1'b0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        state     <= ERASE;
                        erase     <= 1'b1;
                        busy      <= 1'b1;
                        phase_cnt <= '0;
                    end
                end
                ERASE: begin
                    if (phase_cnt == PHASE_W'(ERASE_CYCLES - 1)) begin
                        state     <= EXPOSE;
                        erase     <= 1'b0;
                        expose    <= 1'b1;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                EXPOSE: begin
                    if (phase_cnt == PHASE_W'(EXPOSE_CYCLES - 1)) begin
                        state  <= CONVERT;
                        expose <= 1'b0;
                        ramp   <= 1'b1;
                        slot   <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                CONVERT: begin
                    // ramp high marks the A half of a slot; the B half samples and decides.
                    if (ramp) begin
                        ramp <= 1'b0;
                    end else if (all_tripped || (slot == LAST_SLOT)) begin
                        state      <= READOUT;
                        data_valid <= 1'b1;
                        pix_index  <= '0;
                    end else begin
                        slot <= slot + 1'b1;
                        ramp <= 1'b1;
                    end
                end
                READOUT: begin
                    if (transfer) begin
                        if (last_pixel) begin
                            state      <= IDLE;
                            data_valid <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            pix_index  <= '0;
                        end else begin
                            pix_index <= pix_index + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_sensor_controller.sv
// Randomised frame-level bench for pixel_sensor_controller: comparator trip slots are chosen per
// pixel and the expected codes, phase timing and readout sequence are derived from those slots.
module tb_pixel_sensor_controller;

    localparam int PIXEL_BITS    = 8;
    localparam int NUM_PIXELS    = 4;
    localparam int ERASE_CYCLES  = 4;
    localparam int EXPOSE_CYCLES = 10;
    localparam int SLOTS         = 1 << PIXEL_BITS;
    localparam int PRE_CONVERT   = ERASE_CYCLES + EXPOSE_CYCLES;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  start = 1'b0;
    logic [NUM_PIXELS-1:0] cmp = '0;
    logic                  data_ready = 1'b0;
    logic                  erase;
    logic                  expose;
    logic                  ramp;
    logic                  busy;
    logic [PIXEL_BITS-1:0] data;
    logic [1:0]            pix_index;
    logic                  data_valid;
    logic                  frame_done;

    int errors = 0;
    int checks = 0;

    // Slot in whose B cycle each pixel's comparator rises; -1 = high from frame start, >=SLOTS = never.
    int trip [NUM_PIXELS];

    pixel_sensor_controller #(
        .PIXEL_BITS    (PIXEL_BITS),
        .NUM_PIXELS    (NUM_PIXELS),
        .ERASE_CYCLES  (ERASE_CYCLES),
        .EXPOSE_CYCLES (EXPOSE_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cmp        (cmp),
        .erase      (erase),
        .expose     (expose),
        .ramp       (ramp),
        .busy       (busy),
        .data       (data),
        .pix_index  (pix_index),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, expected, $time);
        end
    endtask

    function automatic int expected_code(input int t);
        if (t < 0) return 0;
        if (t >= SLOTS) return SLOTS - 1;
        return t;
    endfunction

    function automatic int slots_used();
        int last;
        last = 0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            if (trip[i] >= SLOTS) return SLOTS;
            if (trip[i] > last) last = trip[i];
        end
        return last + 1;
    endfunction

    function automatic logic [15:0] all_outputs();
        return {erase, expose, ramp, busy, data_valid, frame_done, pix_index, data};
    endfunction

    // Runs one frame from start to the idle cycle after frame_done; abort_slot >= 0 pulls reset
    // in the A cycle of that slot instead of finishing the frame.
    task automatic applyStimulus(input int ready_mode, input int abort_slot);
        int          slots;
        int          conv_end;
        int          idx;
        int          stalls;
        int          guard;
        int          exp_code [NUM_PIXELS];
        logic [5:0]  exp_ctl;
        slots = slots_used();
        for (int i = 0; i < NUM_PIXELS; i++) exp_code[i] = expected_code(trip[i]);
        conv_end = PRE_CONVERT + 2 * slots;

        start = 1'b1;
        cmp = '0;
        data_ready = 1'b0;
        @(posedge clk); #1;

        for (int n = 1; n <= conv_end; n++) begin
            for (int i = 0; i < NUM_PIXELS; i++)
                cmp[i] = (trip[i] < 0) || (trip[i] < SLOTS && n >= PRE_CONVERT + 2 * trip[i] + 2);
            start = 1'($urandom_range(0, 1));
            data_ready = 1'($urandom_range(0, 1));
            if (abort_slot >= 0 && n == PRE_CONVERT + 2 * abort_slot + 1) begin
                reset = 1'b0;
                #1;
                checkOutput("abort_outputs", 32'(all_outputs()), 32'd0);
                repeat (3) @(posedge clk);
                #1;
                reset = 1'b1;
                start = 1'b0;
                cmp = '0;
                @(posedge clk); #1;
                checkOutput("abort_idle", {28'd0, busy, frame_done, data_valid, erase}, 32'd0);
                return;
            end
            exp_ctl = {n <= ERASE_CYCLES,
                       n > ERASE_CYCLES && n <= PRE_CONVERT,
                       n > PRE_CONVERT && ((n - PRE_CONVERT) % 2 == 1),
                       1'b1, 1'b0, 1'b0};
            checkOutput("phase_outputs", {26'd0, erase, expose, ramp, busy, data_valid, frame_done},
                        {26'd0, exp_ctl});
            @(posedge clk); #1;
        end

        idx = 0;
        stalls = 0;
        guard = 0;
        while (idx < NUM_PIXELS && guard < 200) begin
            start = 1'($urandom_range(0, 1));
            case (ready_mode)
                0:       data_ready = 1'b1;
                1:       data_ready = 1'($urandom_range(0, 1));
                default: data_ready = !(idx == 1 && stalls < 7);
            endcase
            checkOutput("readout_valid", {31'd0, data_valid}, 32'd1);
            checkOutput("readout_index", {30'd0, pix_index}, 32'(idx));
            checkOutput("readout_data", {24'd0, data}, 32'(exp_code[idx]));
            checkOutput("readout_ctl", {27'd0, busy, frame_done, erase, expose, ramp}, 32'b10000);
            if (data_ready) idx++;
            else if (idx == 1) stalls++;
            guard++;
            @(posedge clk); #1;
        end
        checkOutput("readout_bounded", {31'd0, guard < 200}, 32'd1);

        start = 1'b1;
        data_ready = 1'($urandom_range(0, 1));
        checkOutput("frame_done_pulse", {29'd0, data_valid, frame_done, busy}, 32'b010);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("after_frame_idle", {28'd0, frame_done, busy, erase, data_valid}, 32'd0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1));
            cmp = NUM_PIXELS'($urandom);
            checkOutput("reset_outputs", 32'(all_outputs()), 32'd0);
        end
        start = 1'b0;
        cmp = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_release_idle", {31'd0, busy}, 32'd0);

        trip = '{10, 0, 200, 255};
        applyStimulus(0, -1);

        trip = '{3, -1, SLOTS, 7};
        applyStimulus(2, -1);

        trip = '{5, 2, 0, 4};
        applyStimulus(2, -1);

        trip = '{20, 50, 30, 70};
        applyStimulus(1, 37);

        trip = '{SLOTS, 2, 3, 4};
        applyStimulus(1, -1);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NUM_PIXELS; i++)
                trip[i] = int'($urandom_range(0, 270)) - 1;
            applyStimulus(1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
